ram16k_arbiter: RTL and testbench
=================================

RAM16K_ARBITER -- requirements
Module: ram16k_arbiter

Interface
REQ-001 Parameter CLEAR_VALUE, default 16'h0000: word written to every location during a clear sweep.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 a_req  input  1  port A request, held until granted.
REQ-005 a_we  input  1  port A write (1) / read (0), qualified by a_req.
REQ-006 a_addr  input  14  port A word address.
REQ-007 a_wdata  input  16  port A write data.
REQ-008 a_gnt  output  1  port A request accepted this cycle (combinational).
REQ-009 a_rvalid  output  1  port A read data valid, registered one-cycle pulse.
REQ-010 a_rdata  output  16  port A read data, registered.
REQ-011 b_req, b_we, b_addr[13:0], b_wdata[15:0], b_gnt, b_rvalid, b_rdata[15:0]: port B, same directions, widths and meanings as port A.
REQ-012 clear_start  input  1  one-cycle pulse requesting a full-memory clear.
REQ-013 busy  output  1  clear sweep in progress.
REQ-014 clear_done  output  1  one-cycle pulse after the last clear write.
REQ-015 mem_in  output  16  to RAM16K in.
REQ-016 mem_address  output  14  to RAM16K address.
REQ-017 mem_load  output  1  to RAM16K load.
REQ-018 mem_out  input  16  from RAM16K out (combinational read of mem_address).

Function
REQ-019 FSM has two states, IDLE and CLEAR; reset state is IDLE.
REQ-020 In IDLE with clear_start=0, at most one port is granted per cycle; a lone requester is granted the same cycle.
REQ-021 In IDLE with both a_req and b_req, the port not granted most recently wins (round-robin); last_grant updates only on an actual grant.
REQ-022 Granted port drives mem_address=its addr, mem_in=its wdata, mem_load=its we; without a grant mem_load=0, mem_address and mem_in are held at 0.
REQ-023 Granted write: RAM updates at that rising edge; no rvalid is produced.
REQ-024 Granted read: mem_out is captured into x_rdata at that edge; x_rvalid=1 for exactly the next cycle; x_rdata holds its value until the next read on that port.
REQ-025 Read latency is one cycle from grant; back-to-back grants to one port give back-to-back rvalid pulses.
REQ-026 clear_start in IDLE takes priority over requests: no grant that cycle; next state CLEAR, 14-bit counter := 0.
REQ-027 In CLEAR: busy=1, a_gnt=b_gnt=0, mem_load=1, mem_in=CLEAR_VALUE, mem_address=counter; counter increments each cycle.
REQ-028 CLEAR lasts exactly 16384 cycles (addresses 0..16383); after the write at 16383, next state IDLE and the counter wraps to 0.
REQ-029 clear_done=1 for the single cycle immediately after the last clear write; requests may be granted in that same cycle.
REQ-030 clear_start during CLEAR is ignored; the sweep does not restart.
REQ-031 Requests pending during CLEAR stay ungranted and are served under round-robin once IDLE resumes; last_grant is unchanged by CLEAR.
REQ-032 Same address requested by both ports: only the granted one accesses memory that cycle; no merging.

Reset
REQ-033 reset asserted forces immediately, regardless of clk: state=IDLE, counter=0, last_grant=B (so A wins the first tie), busy=0, clear_done=0, a_rvalid=b_rvalid=0, a_rdata=b_rdata=0.
REQ-034 reset during CLEAR aborts the sweep with no clear_done; locations not yet written keep their old contents.
REQ-035 Grant and mem_* outputs are combinational; while reset is held with requests present they follow REQ-020..022 from the reset state. Memory contents are not reset.

Verification
REQ-036 After reset: a_req=1, a_we=1, a_addr=14'h0005, a_wdata=16'h1234; then a read of 14'h0005 -> a_gnt same cycle, a_rvalid next cycle with a_rdata=16'h1234.
REQ-037 a_req and b_req both held as reads for 4 cycles -> grants A,B,A,B; each rvalid one cycle after its grant.
REQ-038 clear_start with a_req also high -> no a_gnt; busy for 16384 cycles; clear_done once; then a_gnt; every sampled address reads 16'h0000.
REQ-039 clear_start pulsed again at sweep address 100 -> busy still ends after 16384 total cycles; exactly one clear_done.
REQ-040 reset asserted at sweep address 8000, with address 9000 preloaded to 16'hBEEF -> busy=0 immediately; no clear_done; address 9000 reads 16'hBEEF, address 10 reads 16'h0000.
REQ-041 b write 16'hAAAA to 14'h3FFF with a_req low -> b_gnt, mem_load=1, mem_address=14'h3FFF; a following b read returns 16'hAAAA.

Source files
------------

// File: rtl/ram16k_arbiter.sv
// Two-port round-robin arbiter in front of a single-port 16K x 16 RAM.
// It also provides a full-memory clear sweep that writes CLEAR_VALUE to
// every word. Grants and mem_* outputs are combinational. Read data, read
// valid, busy and clear_done are registered.
module ram16k_arbiter #(
  parameter logic [15:0] CLEAR_VALUE = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [13:0] a_addr,
  input  logic [15:0] a_wdata,
  output logic        a_gnt,
  output logic        a_rvalid,
  output logic [15:0] a_rdata,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [13:0] b_addr,
  input  logic [15:0] b_wdata,
  output logic        b_gnt,
  output logic        b_rvalid,
  output logic [15:0] b_rdata,
  input  logic        clear_start,
  output logic        busy,
  output logic        clear_done,
  output logic [15:0] mem_in,
  output logic [13:0] mem_address,
  output logic        mem_load,
  input  logic [15:0] mem_out
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam logic [13:0] LAST_ADDR = 14'h3FFF;

  state_t      r_state;
  logic [13:0] r_count;
  logic        r_last_b;      // 1: port B was granted most recently
  logic        r_busy;
  logic        r_clear_done;
  logic        r_a_rvalid;
  logic [15:0] r_a_rdata;
  logic        r_b_rvalid;
  logic [15:0] r_b_rdata;

  logic        w_accept;
  logic        w_a_gnt;
  logic        w_b_gnt;
  logic [15:0] w_mem_in;
  logic [13:0] w_mem_address;
  logic        w_mem_load;

  // A pending clear_start outranks both ports. On a tie, the port that was
  // not served last gets the grant.
  assign w_accept = (r_state == ST_IDLE) & ~clear_start;
  assign w_a_gnt  = w_accept & a_req & (~b_req | r_last_b);
  assign w_b_gnt  = w_accept & b_req & ~w_a_gnt;

  // RAM port mux: the clear sweep, the granted port, or quiet zeros
  always_comb begin
    w_mem_in      = 16'h0000;
    w_mem_address = 14'h0000;
    w_mem_load    = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        w_mem_in      = CLEAR_VALUE;
        w_mem_address = r_count;
        w_mem_load    = 1'b1;
      end
      ST_IDLE: begin
        if (w_a_gnt) begin
          w_mem_in      = a_wdata;
          w_mem_address = a_addr;
          w_mem_load    = a_we;
        end else if (w_b_gnt) begin
          w_mem_in      = b_wdata;
          w_mem_address = b_addr;
          w_mem_load    = b_we;
        end else begin
          w_mem_in      = 16'h0000;
          w_mem_address = 14'h0000;
          w_mem_load    = 1'b0;
        end
      end
      default: begin
        w_mem_in      = 16'h0000;
        w_mem_address = 14'h0000;
        w_mem_load    = 1'b0;
      end
    endcase
  end

  // Control FSM: sweep counter, busy/done flags and round-robin history
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_count      <= 14'h0000;
      r_last_b     <= 1'b1;
      r_busy       <= 1'b0;
      r_clear_done <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_clear_done <= 1'b0;
          if (clear_start) begin
            r_state <= ST_CLEAR;
            r_count <= 14'h0000;
            r_busy  <= 1'b1;
          end else if (w_a_gnt) begin
            r_last_b <= 1'b0;
          end else if (w_b_gnt) begin
            r_last_b <= 1'b1;
          end
        end
        ST_CLEAR: begin
          // clear_start is deliberately ignored here so a sweep never restarts
          if (r_count == LAST_ADDR) begin
            r_state      <= ST_IDLE;
            r_count      <= 14'h0000;
            r_busy       <= 1'b0;
            r_clear_done <= 1'b1;
          end else begin
            r_count      <= r_count + 14'h0001;
            r_clear_done <= 1'b0;
          end
        end
        default: begin
          r_state      <= ST_IDLE;
          r_count      <= 14'h0000;
          r_busy       <= 1'b0;
          r_clear_done <= 1'b0;
        end
      endcase
    end
  end

  // Port A read return: capture RAM output on a granted read, pulse valid once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a_rvalid <= 1'b0;
      r_a_rdata  <= 16'h0000;
    end else if (w_a_gnt && !a_we) begin
      r_a_rvalid <= 1'b1;
      r_a_rdata  <= mem_out;
    end else begin
      r_a_rvalid <= 1'b0;
    end
  end

  // Port B read return: capture RAM output on a granted read, pulse valid once
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_b_rvalid <= 1'b0;
      r_b_rdata  <= 16'h0000;
    end else if (w_b_gnt && !b_we) begin
      r_b_rvalid <= 1'b1;
      r_b_rdata  <= mem_out;
    end else begin
      r_b_rvalid <= 1'b0;
    end
  end

  assign a_gnt       = w_a_gnt;
  assign b_gnt       = w_b_gnt;
  assign a_rvalid    = r_a_rvalid;
  assign a_rdata     = r_a_rdata;
  assign b_rvalid    = r_b_rvalid;
  assign b_rdata     = r_b_rdata;
  assign busy        = r_busy;
  assign clear_done  = r_clear_done;
  assign mem_in      = w_mem_in;
  assign mem_address = w_mem_address;
  assign mem_load    = w_mem_load;

endmodule

// File: tb/tb_ram16k_arbiter.sv
// Testbench for ram16k_arbiter. It contains a behavioural RAM16K and a
// transaction-level reference model. The model keeps a shadow memory, the
// round-robin history, and the progress of the clear sweep.
module tb_ram16k_arbiter;

  localparam logic [15:0] CV = 16'h0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_req, a_we, b_req, b_we, clear_start;
  logic [13:0] a_addr, b_addr;
  logic [15:0] a_wdata, b_wdata;
  logic        a_gnt, a_rvalid, b_gnt, b_rvalid, busy, clear_done, mem_load;
  logic [15:0] a_rdata, b_rdata, mem_in, mem_out;
  logic [13:0] mem_address;

  logic [15:0] ram [16384];
  logic [15:0] shadow [16384];

  // reference model state
  bit          m_last_b, m_busy;
  int          m_cnt;
  logic        e_ag, e_bg, e_load, e_arv, e_brv, e_done;
  logic [13:0] e_addr;
  logic [15:0] e_in, e_ard, e_brd;

  int n_cmp = 0;
  int n_err = 0;

  ram16k_arbiter #(.CLEAR_VALUE(CV)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .clear_start(clear_start), .busy(busy), .clear_done(clear_done),
    .mem_in(mem_in), .mem_address(mem_address), .mem_load(mem_load),
    .mem_out(mem_out)
  );

  always #5 clk = ~clk;

  // behavioural RAM16K: synchronous write, combinational read
  always @(posedge clk) if (mem_load) ram[mem_address] <= mem_in;
  assign mem_out = ram[mem_address];

  task automatic model_reset();
    m_last_b = 1'b1; m_busy = 1'b0; m_cnt = 0;
    e_arv = 1'b0; e_brv = 1'b0; e_done = 1'b0; e_ard = 16'h0000; e_brd = 16'h0000;
  endtask

  // expected combinational outputs, derived from the current inputs
  task automatic model_comb();
    e_ag = 1'b0; e_bg = 1'b0; e_load = 1'b0; e_addr = 14'h0000; e_in = 16'h0000;
    if (m_busy) begin
      e_load = 1'b1; e_addr = 14'(m_cnt); e_in = CV;
    end else if (!clear_start) begin
      if (a_req && (!b_req || m_last_b)) e_ag = 1'b1;
      else if (b_req) e_bg = 1'b1;
      if (e_ag) {e_load, e_addr, e_in} = {a_we, a_addr, a_wdata};
      else if (e_bg) {e_load, e_addr, e_in} = {b_we, b_addr, b_wdata};
    end
  endtask

  // advance the model over one rising edge
  task automatic model_tick();
    e_arv = 1'b0; e_brv = 1'b0; e_done = 1'b0;
    if (m_busy) begin
      shadow[m_cnt] = CV;
      if (m_cnt == 16383) begin m_busy = 1'b0; m_cnt = 0; e_done = 1'b1; end
      else m_cnt++;
    end else if (clear_start) begin
      m_busy = 1'b1; m_cnt = 0;
    end else if (e_ag) begin
      m_last_b = 1'b0;
      if (a_we) shadow[a_addr] = a_wdata;
      else begin e_arv = 1'b1; e_ard = shadow[a_addr]; end
    end else if (e_bg) begin
      m_last_b = 1'b1;
      if (b_we) shadow[b_addr] = b_wdata;
      else begin e_brv = 1'b1; e_brd = shadow[b_addr]; end
    end
  endtask

  task automatic drive(input logic cs,
                       input logic ar, input logic aw, input logic [13:0] aa, input logic [15:0] ad,
                       input logic br, input logic bw, input logic [13:0] ba, input logic [15:0] bd);
    clear_start = cs;
    a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
    b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
    #1 model_comb();
  endtask

  task automatic tick();
    @(posedge clk);
    model_tick();
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 14'h0, 16'h0, 1'b0, 1'b0, 14'h0, 16'h0);
    model_reset();
    @(posedge clk);
    #3 reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    model_reset();
    drive(1'b0, 1'b1, 1'b0, 14'h0021, 16'h0, 1'b1, 1'b0, 14'h0042, 16'h0);
    n_cmp++;
    if ({a_rvalid, a_rdata, b_rvalid, b_rdata, busy, clear_done} !== 35'h0) begin
      n_err++; $display("FAIL reset_regs got=%h exp=0", {a_rvalid, a_rdata, b_rvalid, b_rdata, busy, clear_done});
    end
    n_cmp++;
    if ({a_gnt, b_gnt, mem_load, mem_address} !== {1'b1, 1'b0, 1'b0, 14'h0021}) begin
      n_err++; $display("FAIL reset_grant got=%b%b%b %h exp=100 0021", a_gnt, b_gnt, mem_load, mem_address);
    end
    apply_reset();
  endtask

  task automatic test_write_read_a();
    drive(1'b0, 1'b1, 1'b1, 14'h0005, 16'h1234, 1'b0, 1'b0, 14'h0, 16'h0);
    n_cmp++;
    if ({a_gnt, mem_load, mem_address, mem_in} !== {1'b1, 1'b1, 14'h0005, 16'h1234}) begin
      n_err++; $display("FAIL a_write_comb got=%b%b %h %h", a_gnt, mem_load, mem_address, mem_in);
    end
    tick();
    drive(1'b0, 1'b1, 1'b0, 14'h0005, 16'h0, 1'b0, 1'b0, 14'h0, 16'h0);
    n_cmp++;
    if ({a_gnt, a_rvalid} !== 2'b10) begin
      n_err++; $display("FAIL a_read_gnt got=%b%b exp=10", a_gnt, a_rvalid);
    end
    tick();
    n_cmp++;
    if ({a_rvalid, a_rdata} !== {1'b1, 16'h1234} || {a_rvalid, a_rdata} !== {e_arv, e_ard}) begin
      n_err++; $display("FAIL a_read_data got=%b %h exp=1 1234", a_rvalid, a_rdata);
    end
    drive(1'b0, 1'b0, 1'b0, 14'h0, 16'h0, 1'b0, 1'b0, 14'h0, 16'h0);
    tick();
    n_cmp++;
    if ({a_rvalid, a_rdata} !== {1'b0, 16'h1234}) begin
      n_err++; $display("FAIL a_rdata_hold got=%b %h exp=0 1234", a_rvalid, a_rdata);
    end
  endtask

  task automatic test_round_robin();
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 1'b0, 14'($urandom_range(0, 16383)), 16'h0,
            1'b1, 1'b0, 14'($urandom_range(0, 16383)), 16'h0);
      n_cmp++;
      if ({a_gnt, b_gnt} !== ((i % 2 == 0) ? 2'b10 : 2'b01) ||
          {a_gnt, b_gnt, mem_load, mem_address, mem_in} !== {e_ag, e_bg, e_load, e_addr, e_in}) begin
        n_err++; $display("FAIL rr_grant cyc=%0d got=%b%b %h exp=%b%b %h", i, a_gnt, b_gnt, mem_address, e_ag, e_bg, e_addr);
      end
      tick();
      n_cmp++;
      if ({a_rvalid, b_rvalid} !== ((i % 2 == 0) ? 2'b10 : 2'b01) ||
          {a_rvalid, a_rdata, b_rvalid, b_rdata} !== {e_arv, e_ard, e_brv, e_brd}) begin
        n_err++; $display("FAIL rr_rvalid cyc=%0d got=%b %h %b %h exp=%b %h %b %h", i,
                          a_rvalid, a_rdata, b_rvalid, b_rdata, e_arv, e_ard, e_brv, e_brd);
      end
    end
  endtask

  task automatic test_b_top_addr();
    drive(1'b0, 1'b0, 1'b0, 14'h0, 16'h0, 1'b1, 1'b1, 14'h3FFF, 16'hAAAA);
    n_cmp++;
    if ({a_gnt, b_gnt, mem_load, mem_address, mem_in} !== {1'b0, 1'b1, 1'b1, 14'h3FFF, 16'hAAAA}) begin
      n_err++; $display("FAIL b_write_top got=%b%b%b %h %h", a_gnt, b_gnt, mem_load, mem_address, mem_in);
    end
    tick();
    drive(1'b0, 1'b0, 1'b0, 14'h0, 16'h0, 1'b1, 1'b0, 14'h3FFF, 16'h0);
    tick();
    n_cmp++;
    if ({b_rvalid, b_rdata} !== {1'b1, 16'hAAAA} || b_rdata !== e_brd) begin
      n_err++; $display("FAIL b_read_top got=%b %h exp=1 aaaa", b_rvalid, b_rdata);
    end
  endtask

  task automatic test_random();
    logic ar, aw, br, bw;
    logic [13:0] aa, ba;
    logic [15:0] ad, bd;
    ar = 1'b0; aw = 1'b0; br = 1'b0; bw = 1'b0; aa = 14'h0; ba = 14'h0; ad = 16'h0; bd = 16'h0;
    for (int i = 0; i < 400; i++) begin
      // a request that was not granted stays asserted with the same fields
      if (!(ar && !e_ag)) begin
        ar = 1'($urandom_range(0, 1)); aw = 1'($urandom_range(0, 1));
        aa = 14'($urandom_range(0, 15)); ad = 16'($urandom);
      end
      if (!(br && !e_bg)) begin
        br = 1'($urandom_range(0, 1)); bw = 1'($urandom_range(0, 1));
        ba = 14'($urandom_range(0, 15)); bd = 16'($urandom);
      end
      drive(1'b0, ar, aw, aa, ad, br, bw, ba, bd);
      n_cmp++;
      if ({a_gnt, b_gnt, mem_load, mem_address, mem_in} !== {e_ag, e_bg, e_load, e_addr, e_in}) begin
        n_err++; $display("FAIL rand_comb cyc=%0d got=%h exp=%h", i,
                          {a_gnt, b_gnt, mem_load, mem_address, mem_in}, {e_ag, e_bg, e_load, e_addr, e_in});
      end
      tick();
      n_cmp++;
      if ({a_rvalid, a_rdata, b_rvalid, b_rdata} !== {e_arv, e_ard, e_brv, e_brd}) begin
        n_err++; $display("FAIL rand_read cyc=%0d got=%h exp=%h", i,
                          {a_rvalid, a_rdata, b_rvalid, b_rdata}, {e_arv, e_ard, e_brv, e_brd});
      end
    end
    drive(1'b0, 1'b0, 1'b0, 14'h0, 16'h0, 1'b0, 1'b0, 14'h0, 16'h0);
    tick();
  endtask

  task automatic test_clear(input int restart_at);
    int busy_n, done_n, k, cmp_bad;
    logic [13:0] pa;
    pa = 14'($urandom_range(0, 16383));
    drive(1'b1, 1'b1, 1'b0, pa, 16'h0, 1'b0, 1'b0, 14'h0, 16'h0);
    n_cmp++;
    if ({a_gnt, b_gnt, mem_load} !== 3'b000) begin
      n_err++; $display("FAIL clr_start_nogrant got=%b%b%b exp=000", a_gnt, b_gnt, mem_load);
    end
    tick();
    busy_n = (busy === 1'b1) ? 1 : 0;
    done_n = 0; k = 0; cmp_bad = 0;
    while (busy === 1'b1 && k < 17000) begin
      drive((k == restart_at) ? 1'b1 : 1'b0, 1'b1, 1'b0, pa, 16'h0, 1'b0, 1'b0, 14'h0, 16'h0);
      if ({a_gnt, b_gnt, mem_load, mem_address, mem_in} !== {e_ag, e_bg, e_load, e_addr, e_in}) cmp_bad++;
      tick();
      if ({busy, clear_done} !== {m_busy, e_done}) cmp_bad++;
      if (busy === 1'b1) busy_n++;
      if (clear_done === 1'b1) done_n++;
      k++;
    end
    n_cmp++;
    if (cmp_bad != 0 || k >= 17000) begin
      n_err++; $display("FAIL clr_sweep bad_cycles=%0d iters=%0d exp=0 <17000", cmp_bad, k);
    end
    n_cmp++;
    if (busy_n != 16384 || done_n != 1) begin
      n_err++; $display("FAIL clr_length busy=%0d done=%0d exp=16384 1", busy_n, done_n);
    end
    // the cycle carrying clear_done may already grant the held request
    drive(1'b0, 1'b1, 1'b0, pa, 16'h0, 1'b0, 1'b0, 14'h0, 16'h0);
    n_cmp++;
    if ({a_gnt, clear_done, busy} !== 3'b110 || a_gnt !== e_ag) begin
      n_err++; $display("FAIL clr_done_grant got=%b%b%b exp=110", a_gnt, clear_done, busy);
    end
    tick();
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b1, 1'b0, 14'($urandom_range(0, 16383)), 16'h0, 1'b0, 1'b0, 14'h0, 16'h0);
      tick();
      n_cmp++;
      if ({a_rvalid, a_rdata} !== {1'b1, 16'h0000} || a_rdata !== e_ard || clear_done !== 1'b0) begin
        n_err++; $display("FAIL clr_readback i=%0d got=%b %h done=%b exp=1 0000 0", i, a_rvalid, a_rdata, clear_done);
      end
    end
  endtask

  task automatic test_reset_during_clear();
    int k, done_n;
    drive(1'b0, 1'b1, 1'b1, 14'd9000, 16'hBEEF, 1'b0, 1'b0, 14'h0, 16'h0); tick();
    drive(1'b0, 1'b0, 1'b0, 14'h0, 16'h0, 1'b1, 1'b1, 14'd10, 16'h5555); tick();
    drive(1'b1, 1'b0, 1'b0, 14'h0, 16'h0, 1'b0, 1'b0, 14'h0, 16'h0); tick();
    k = 0; done_n = 0;
    while (m_cnt != 8000 && k < 9000) begin
      drive(1'b0, 1'b0, 1'b0, 14'h0, 16'h0, 1'b0, 1'b0, 14'h0, 16'h0);
      tick();
      if (clear_done === 1'b1) done_n++;
      k++;
    end
    n_cmp++;
    if (busy !== 1'b1 || mem_address !== 14'd8000) begin
      n_err++; $display("FAIL rst_clr_pos got busy=%b addr=%0d exp=1 8000", busy, mem_address);
    end
    reset = 1'b1;
    #1;
    n_cmp++;
    if ({busy, clear_done, a_rvalid, b_rvalid, mem_load} !== 5'b00000) begin
      n_err++; $display("FAIL rst_clr_async got=%b exp=00000", {busy, clear_done, a_rvalid, b_rvalid, mem_load});
    end
    model_reset();
    @(posedge clk);
    #3 reset = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 14'd9000, 16'h0, 1'b0, 1'b0, 14'h0, 16'h0); tick();
    if (clear_done === 1'b1) done_n++;
    n_cmp++;
    if ({a_rvalid, a_rdata} !== {1'b1, 16'hBEEF} || a_rdata !== e_ard) begin
      n_err++; $display("FAIL rst_clr_9000 got=%b %h exp=1 beef", a_rvalid, a_rdata);
    end
    drive(1'b0, 1'b0, 1'b0, 14'h0, 16'h0, 1'b1, 1'b0, 14'd10, 16'h0); tick();
    if (clear_done === 1'b1) done_n++;
    n_cmp++;
    if ({b_rvalid, b_rdata} !== {1'b1, 16'h0000} || b_rdata !== e_brd) begin
      n_err++; $display("FAIL rst_clr_10 got=%b %h exp=1 0000", b_rvalid, b_rdata);
    end
    n_cmp++;
    if (done_n != 0) begin
      n_err++; $display("FAIL rst_clr_nodone got=%0d exp=0", done_n);
    end
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) begin ram[i] = 16'h0000; shadow[i] = 16'h0000; end
    reset = 1'b1;
    clear_start = 1'b0; a_req = 1'b0; a_we = 1'b0; a_addr = 14'h0; a_wdata = 16'h0;
    b_req = 1'b0; b_we = 1'b0; b_addr = 14'h0; b_wdata = 16'h0;
    #12;
    test_reset();
    test_write_read_a();
    test_round_robin();
    test_b_top_addr();
    test_random();
    test_clear(-1);
    test_clear(100);
    test_reset_during_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached compared=%0d mismatched=%0d", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

endmodule
